enc_chan_sel: RTL and testbench

Parametrised encoder-driven ADC channel selector.
- Keeps a requested channel (`target`) that the rotary encoder pulses `cw`/`ccw` step, or that an auto-scan timer advances.
- Commits `target` to the ADC-facing `chan` output only when the ADC is not mid-conversion.
- Sits between the encoder decoder module and the ADC interface.
- Supports non-power-of-2 channel counts and either wrap or saturate at the ends.

---
 rtl/enc_chan_pkg.sv | 37 +++
 rtl/dwell_timer.sv | 46 ++++
 rtl/enc_chan_sel.sv | 90 +++++++++
 tb/tb_enc_chan_sel.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_chan_pkg.sv
// ============================================================================
// Module   : enc_chan_pkg
// Brief    : Shared types and channel-step arithmetic for enc_chan_sel.
// Revision : 1.0
// ============================================================================
`default_nettype none

package enc_chan_pkg;

    localparam logic [0:0] MODE_MANUAL = 1'b0;
    localparam logic [0:0] MODE_SCAN   = 1'b1;

    typedef enum logic [0:0] {
        MANUAL = MODE_MANUAL,
        SCAN   = MODE_SCAN
    } mode_t;

    typedef int unsigned idx_t;

    // Next channel index modulo n; without wrap the ends are sticky.
    function automatic idx_t chan_step(input idx_t cur, input logic up,
                                       input idx_t n, input logic wrap);
        idx_t nxt;
        nxt = cur;
        if (up) begin
            if (cur >= n - 1) nxt = wrap ? 0 : n - 1;
            else              nxt = cur + 1;
        end else begin
            if (cur == 0)     nxt = wrap ? n - 1 : 0;
            else              nxt = cur - 1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module   : dwell_timer
// Brief    : Free-running 0..DWELL-1 counter with a tick on the last count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

`default_nettype wire

// File: rtl/enc_chan_sel.sv
// ============================================================================
// Module   : enc_chan_sel
// Brief    : Encoder/auto-scan ADC channel selector with busy-deferred commit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module enc_chan_sel
    import enc_chan_pkg::*;
#(
    parameter int NUM_CHAN = 8,
    parameter bit WRAP     = 1'b1,
    parameter int DWELL    = 50_000_000,
    localparam int CHAN_W  = $clog2(NUM_CHAN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cw,
    input  logic              ccw,
    input  logic              scan_en,
    input  logic              adc_busy,
    output logic [CHAN_W-1:0] chan,
    output logic              chan_upd,
    output logic [CHAN_W-1:0] target,
    output logic              pending
);

    mode_t             mode_q, mode_d;
    logic [CHAN_W-1:0] target_q, target_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              chan_upd_q, chan_upd_d;
    logic              dwell_clr;
    logic              dwell_en;
    logic              dwell_tick;
    logic              commit;

    // Held clear through MANUAL so each SCAN entry starts a full dwell period.
    assign dwell_clr = (mode_q == MANUAL);
    assign dwell_en  = (mode_q == SCAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (dwell_clr),
        .en      (dwell_en),
        .tick    (dwell_tick)
    );

    always_comb begin
        mode_d   = scan_en ? SCAN : MANUAL;
        target_d = target_q;
        if (mode_q == SCAN) begin
            if (dwell_tick)
                target_d = CHAN_W'(chan_step(idx_t'(target_q), 1'b1, NUM_CHAN, 1'b1));
        end else if (cw && !ccw) begin
            target_d = CHAN_W'(chan_step(idx_t'(target_q), 1'b1, NUM_CHAN, WRAP));
        end else if (ccw && !cw) begin
            target_d = CHAN_W'(chan_step(idx_t'(target_q), 1'b0, NUM_CHAN, WRAP));
        end

        // Commit the latest target only; intermediate steps under busy vanish.
        commit     = (target_q != chan_q) && !adc_busy;
        chan_d     = commit ? target_q : chan_q;
        chan_upd_d = commit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MANUAL;
            target_q   <= '0;
            chan_q     <= '0;
            chan_upd_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            target_q   <= target_d;
            chan_q     <= chan_d;
            chan_upd_q <= chan_upd_d;
        end
    end

    assign chan     = chan_q;
    assign chan_upd = chan_upd_q;
    assign target   = target_q;
    assign pending  = (target_q != chan_q);

endmodule

`default_nettype wire

// File: tb/tb_enc_chan_sel.sv
// Testbench for enc_chan_sel: one wrapping and one saturating instance
// driven in lockstep and checked against a cycle-level reference model.
`default_nettype none

module tb_enc_chan_sel;

    localparam int NCH   = 5;
    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cw = 1'b0, ccw = 1'b0, scan_en = 1'b0, adc_busy = 1'b0;
    logic [2:0] chan_w, tgt_w, chan_s, tgt_s;
    logic upd_w, pend_w, upd_s, pend_s;

    always #5 clk = ~clk;

    enc_chan_sel #(.NUM_CHAN(NCH), .WRAP(1'b1), .DWELL(DWELL)) u_wrap (
        .clk(clk), .reset_n(reset_n), .cw(cw), .ccw(ccw), .scan_en(scan_en),
        .adc_busy(adc_busy), .chan(chan_w), .chan_upd(upd_w), .target(tgt_w),
        .pending(pend_w));

    enc_chan_sel #(.NUM_CHAN(NCH), .WRAP(1'b0), .DWELL(DWELL)) u_sat (
        .clk(clk), .reset_n(reset_n), .cw(cw), .ccw(ccw), .scan_en(scan_en),
        .adc_busy(adc_busy), .chan(chan_s), .chan_upd(upd_s), .target(tgt_s),
        .pending(pend_s));

    int n_cmp = 0;
    int n_fail = 0;
    int upd_cnt_w = 0;
    int upd_cnt_s = 0;

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    int m_tgt[2];
    int m_chan[2];
    bit m_upd[2];
    bit m_scan;
    int m_age;

    typedef struct {
        bit cw; bit ccw;
        int tw; int ts; int chw; int chs; bit uw; bit us;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_tgt[v] = 0; m_chan[v] = 0; m_upd[v] = 1'b0;
        end
        m_scan = 1'b0;
        m_age  = 0;
    endtask

    task automatic model_edge();
        int nt;
        for (int v = 0; v < 2; v++) begin
            m_upd[v] = (m_tgt[v] != m_chan[v]) && !adc_busy;
            nt = m_tgt[v];
            if (m_scan) begin
                if ((m_age + 1) % DWELL == 0) nt = (nt + 1) % NCH;
            end else if (cw && !ccw) begin
                nt = (v == 0) ? (nt + 1) % NCH : ((nt + 1 > NCH - 1) ? NCH - 1 : nt + 1);
            end else if (ccw && !cw) begin
                nt = (v == 0) ? (nt + NCH - 1) % NCH : ((nt == 0) ? 0 : nt - 1);
            end
            if (m_upd[v]) m_chan[v] = m_tgt[v];
            m_tgt[v] = nt;
        end
        if (m_scan) m_age++;
        if (!m_scan && scan_en) m_age = 0;
        m_scan = scan_en;
    endtask

    task automatic compare_all();
        check("wrap.target",   int'(tgt_w),  m_tgt[0]);
        check("wrap.chan",     int'(chan_w), m_chan[0]);
        check("wrap.chan_upd", int'(upd_w),  int'(m_upd[0]));
        check("wrap.pending",  int'(pend_w), int'(m_tgt[0] != m_chan[0]));
        check("sat.target",    int'(tgt_s),  m_tgt[1]);
        check("sat.chan",      int'(chan_s), m_chan[1]);
        check("sat.chan_upd",  int'(upd_s),  int'(m_upd[1]));
        check("sat.pending",   int'(pend_s), int'(m_tgt[1] != m_chan[1]));
    endtask

    task automatic cycle(input bit c, input bit cc, input bit s, input bit b);
        cw = c; ccw = cc; scan_en = s; adc_busy = b;
        @(posedge clk);
        model_edge();
        #1;
        if (upd_w) upd_cnt_w++;
        if (upd_s) upd_cnt_s++;
        compare_all();
    endtask

    task automatic do_reset();
        cw = 0; ccw = 0; scan_en = 0; adc_busy = 0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
        upd_cnt_w = 0;
        upd_cnt_s = 0;
    endtask

    initial begin
        bit scan_r;
        tbl[0]  = '{1, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 1, 1, 1, 1};
        tbl[2]  = '{1, 0, 2, 2, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 2, 2, 2, 2, 1, 1};
        tbl[4]  = '{1, 0, 3, 3, 2, 2, 0, 0};
        tbl[5]  = '{0, 0, 3, 3, 3, 3, 1, 1};
        tbl[6]  = '{1, 0, 4, 4, 3, 3, 0, 0};
        tbl[7]  = '{0, 0, 4, 4, 4, 4, 1, 1};
        tbl[8]  = '{1, 0, 0, 4, 4, 4, 0, 0};
        tbl[9]  = '{0, 0, 0, 4, 0, 4, 1, 0};
        tbl[10] = '{1, 0, 1, 4, 0, 4, 0, 0};
        tbl[11] = '{0, 0, 1, 4, 1, 4, 1, 0};

        // Six cw pulses from reset: wrap vs saturate.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].cw, tbl[i].ccw, 1'b0, 1'b0);
            check("tbl.target_w", int'(tgt_w),  tbl[i].tw);
            check("tbl.target_s", int'(tgt_s),  tbl[i].ts);
            check("tbl.chan_w",   int'(chan_w), tbl[i].chw);
            check("tbl.chan_s",   int'(chan_s), tbl[i].chs);
            check("tbl.upd_w",    int'(upd_w),  int'(tbl[i].uw));
            check("tbl.upd_s",    int'(upd_s),  int'(tbl[i].us));
        end
        check("tbl.upd_count_w", upd_cnt_w, 6);

        // Saturating: ccw at 0 holds, seven cw stop at 4 with four commits.
        do_reset();
        repeat (2) begin cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); end
        check("sat.ccw_hold", int'(tgt_s), 0);
        repeat (7) begin cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); end
        check("sat.cw_stop", int'(tgt_s), 4);
        check("sat.upd_count", upd_cnt_s, 4);

        // Busy deferral with collapse, then a cancelled step.
        do_reset();
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
        check("busy.pre_chan", int'(chan_w), 2);
        upd_cnt_w = 0;
        cycle(1, 0, 0, 1); cycle(1, 0, 0, 1); cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 1);
        check("busy.target", int'(tgt_w), 3);
        check("busy.pending", int'(pend_w), 1);
        check("busy.chan_held", int'(chan_w), 2);
        check("busy.no_upd", upd_cnt_w, 0);
        cycle(0, 0, 0, 0);
        check("busy.release_chan", int'(chan_w), 3);
        cycle(0, 0, 0, 0);
        check("busy.one_upd", upd_cnt_w, 1);
        upd_cnt_w = 0;
        cycle(1, 0, 0, 1); cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        check("busy.cancel_no_upd", upd_cnt_w, 0);

        // Simultaneous cw and ccw.
        upd_cnt_w = 0;
        cycle(1, 1, 0, 0); cycle(0, 0, 0, 0);
        check("both.target", int'(tgt_w), 3);
        check("both.no_upd", upd_cnt_w, 0);

        // Auto-scan from target 3, encoder ignored, then back to manual.
        cycle(0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            cycle(bit'(i % 2), 1'b0, 1'b1, 1'b0);
            if (i == 4)  check("scan.t4", int'(tgt_w), 4);
            if (i == 8)  check("scan.t8", int'(tgt_w), 0);
            if (i == 12) check("scan.t12", int'(tgt_w), 1);
            if (i == 12) check("scan.t12_sat", int'(tgt_s), 1);
        end
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("scan.manual_cw", int'(tgt_w), 2);

        // Async reset while a commit is pending.
        cycle(1, 0, 0, 1); cycle(1, 0, 0, 1);
        check("rst.pre_target", int'(tgt_w), 4);
        check("rst.pre_chan", int'(chan_w), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst.async_chan", int'(chan_w), 0);
        check("rst.async_target", int'(tgt_w), 0);
        check("rst.async_pending", int'(pend_w), 0);
        check("rst.async_upd", int'(upd_w), 0);
        do_reset();

        // Randomized traffic against the model.
        scan_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) scan_r = !scan_r;
            cycle(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0),
                  scan_r, bit'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
